// File: rtl/mul2_sched.sv
// mul2_sched: control sequencer for the MUL2 4x4 matrix-squaring datapath.
// Loads external operands, runs n_iter back-to-back squarings with result
// feedback, then strobes the downstream capture register and signals done.
// Optional abort support is compiled in when MUL2_SCHED_ABORT_EN is defined.
// All outputs are Moore outputs decoded from the registered state, so the
// asynchronous reset clears them without waiting for a clock edge.
module mul2_sched #(
    parameter int ITER_W  = 4,
    parameter int MUL_LAT = 1   // legal range 1..8
) (
    input  logic              clk_mul,
    input  logic              rstn_mul,
    input  logic              start,
    input  logic [ITER_W-1:0] n_iter,
    output logic              busy,
    output logic              done,
    output logic              ld_in,
    output logic              sel_fb,
    output logic              en_mul,
    output logic              cap_out,
    output logic [ITER_W-1:0] iter_cnt
`ifdef MUL2_SCHED_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    // State encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_FB   = 3'd4;
    localparam logic [2:0] S_CAP  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    // The wait counter counts down MUL_LAT-1 .. 0, so 3 bits cover 1..8.
    localparam logic [2:0]        WAIT_INIT = 3'(MUL_LAT - 1);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [ITER_W-1:0] r_n_iter;
    logic [ITER_W-1:0] r_iter_cnt;
    logic [2:0]        r_wait_cnt;

    logic              w_accept;      // start taken in IDLE this cycle
    logic              w_wait_last;   // final cycle of the latency wait
    logic [ITER_W:0]   w_iter_p1;     // iter_cnt+1, one bit wider so it never wraps
    logic              w_more;        // another squaring still needed
    logic              w_abort;
    logic              w_abort_hit;   // abort honoured on this edge

`ifdef MUL2_SCHED_ABORT_EN
    logic r_aborted;
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_wait_last = (r_state == S_WAIT) && (r_wait_cnt == 3'd0);
    assign w_iter_p1   = {1'b0, r_iter_cnt} + {{ITER_W{1'b0}}, 1'b1};
    assign w_more      = (w_iter_p1 < {1'b0, r_n_iter});
    // Abort is only meaningful while work is in flight; IDLE and DONE ignore it.
    assign w_abort_hit = w_abort && (r_state != S_IDLE) && (r_state != S_DONE);

    // Next-state decode; an honoured abort overrides the normal sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (n_iter == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: w_state_next = S_MUL;
            S_MUL:  w_state_next = S_WAIT;
            S_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_next = w_more ? S_FB : S_CAP;
                end
            end
            S_FB:   w_state_next = S_MUL;
            S_CAP:  w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort_hit) begin
            w_state_next = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the iteration target when a run is accepted; later n_iter changes are ignored
    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul) begin
            r_n_iter <= '0;
        end else if (w_accept) begin
            r_n_iter <= n_iter;
        end
    end

    // Completed-squaring count: cleared on accept, bumped at the end of each wait, held in IDLE
    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul) begin
            r_iter_cnt <= '0;
        end else if (w_accept) begin
            r_iter_cnt <= '0;
        end else if (w_wait_last && !w_abort_hit) begin
            r_iter_cnt <= r_iter_cnt + ITER_ONE;
        end
    end

    // Latency counter: armed in MUL, counts down through WAIT
    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul) begin
            r_wait_cnt <= 3'd0;
        end else if (r_state == S_MUL) begin
            r_wait_cnt <= WAIT_INIT;
        end else if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
        end
    end

`ifdef MUL2_SCHED_ABORT_EN
    // One-cycle abort acknowledge in the cycle after the abort edge
    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort_hit;
        end
    end

    assign aborted = r_aborted;
`endif

    // Moore output decode: at most one of ld_in/en_mul/cap_out/done per state
    always_comb begin
        busy    = (r_state != S_IDLE);
        ld_in   = 1'b0;
        sel_fb  = 1'b0;
        en_mul  = 1'b0;
        cap_out = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_LOAD: ld_in = 1'b1;
            S_FB: begin
                ld_in  = 1'b1;
                sel_fb = 1'b1;
            end
            S_MUL:  en_mul  = 1'b1;
            S_CAP:  cap_out = 1'b1;
            S_DONE: done    = 1'b1;
            default: begin
                ld_in = 1'b0;
            end
        endcase
    end

    assign iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_mul2_sched.sv
// tb_mul2_sched: self-checking bench for mul2_sched.
// Two instances (MUL_LAT=1 and MUL_LAT=3) are checked every cycle against a
// schedule model computed directly from the documented cycle formulas.
// With MUL2_SCHED_ABORT_EN defined, the abort ports are also exercised.
module tb_mul2_sched;

    localparam int IW = 4;

    logic          clk;
    logic          rstn;
    logic          start1, start3;
    logic [IW-1:0] n1, n3;
    logic          busy1, done1, ld1, fb1, en1, cap1;
    logic          busy3, done3, ld3, fb3, en3, cap3;
    logic [IW-1:0] cnt1, cnt3;
`ifdef MUL2_SCHED_ABORT_EN
    logic          abort1, abort3, aborted1, aborted3;
`endif

    int total;
    int bad;

    mul2_sched #(.ITER_W(IW), .MUL_LAT(1)) u_dut1 (
        .clk_mul(clk), .rstn_mul(rstn), .start(start1), .n_iter(n1),
        .busy(busy1), .done(done1), .ld_in(ld1), .sel_fb(fb1),
        .en_mul(en1), .cap_out(cap1), .iter_cnt(cnt1)
`ifdef MUL2_SCHED_ABORT_EN
        , .abort(abort1), .aborted(aborted1)
`endif
    );

    mul2_sched #(.ITER_W(IW), .MUL_LAT(3)) u_dut3 (
        .clk_mul(clk), .rstn_mul(rstn), .start(start3), .n_iter(n3),
        .busy(busy3), .done(done3), .ld_in(ld3), .sel_fb(fb3),
        .en_mul(en3), .cap_out(cap3), .iter_cnt(cnt3)
`ifdef MUL2_SCHED_ABORT_EN
        , .abort(abort3), .aborted(aborted3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {busy,done,ld_in,sel_fb,en_mul,cap_out} in cycle k after a start
    // accepted with count n and latency L (k=1 is the first cycle after acceptance).
    function automatic logic [5:0] exp_vec(input int k, input int n, input int L);
        int p, cap, dn, ph;
        logic [5:0] v;
        v = 6'b000000;
        p = 2 + L;
        if (n == 0) begin
            if (k == 1) v = 6'b110000;
            return v;
        end
        cap = 3 + L + (n - 1) * p;
        dn  = cap + 1;
        if (k == 1) begin
            v = 6'b101000;
        end else if (k >= 2 && k < cap) begin
            ph = (k - 2) % p;
            if (ph == 0)          v = 6'b100010;
            else if (ph == p - 1) v = 6'b101100;
            else                  v = 6'b100000;
        end else if (k == cap) begin
            v = 6'b100001;
        end else if (k == dn) begin
            v = 6'b110000;
        end
        return v;
    endfunction

    // Squarings completed as seen in cycle k: the i-th one finishes its wait in
    // cycle 2+(i-1)(2+L)+L and is counted from the following cycle.
    function automatic logic [IW-1:0] exp_cnt(input int k, input int n, input int L);
        int c;
        logic [31:0] c32;
        c = 0;
        for (int i = 1; i <= n; i++) begin
            if (k >= 3 + L + (i - 1) * (2 + L)) c++;
        end
        c32 = c;
        return c32[IW-1:0];
    endfunction

    function automatic int done_cycle(input int n, input int L);
        if (n == 0) return 1;
        return 4 + L + (n - 1) * (2 + L);
    endfunction

    function automatic logic [9:0] obs1();
        return {busy1, done1, ld1, fb1, en1, cap1, cnt1};
    endfunction

    function automatic logic [9:0] obs3();
        return {busy3, done3, ld3, fb3, en3, cap3, cnt3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        #3;
        got = obs1();
        total++;
        if (got !== 10'h000) begin
            bad++;
            $display("FAIL reset_async_dut1 got=%h want=%h", got, 10'h000);
        end
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        got = obs1();
        total++;
        if (got !== 10'h000) begin
            bad++;
            $display("FAIL reset_idle_dut1 got=%h want=%h", got, 10'h000);
        end
        got = obs3();
        total++;
        if (got !== 10'h000) begin
            bad++;
            $display("FAIL reset_idle_dut3 got=%h want=%h", got, 10'h000);
        end
        $display("reset: both instances idle");
    endtask

    task automatic test_single();
        logic [9:0] got, want;
        n1 = 4'd1;
        start1 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) start1 = 1'b0;
            got  = obs1();
            want = {exp_vec(k, 1, 1), exp_cnt(k, 1, 1)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL single cycle=%0d got=%h want=%h", k, got, want);
            end
        end
        $display("run single: n=1 L=1");
    endtask

    task automatic test_three();
        logic [9:0] got, want;
        n1 = 4'd3;
        start1 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1) start1 = 1'b0;
            got  = obs1();
            want = {exp_vec(k, 3, 1), exp_cnt(k, 3, 1)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL three cycle=%0d got=%h want=%h", k, got, want);
            end
        end
        $display("run three: n=3 L=1");
    endtask

    task automatic test_zero();
        logic [9:0] got, want;
        n1 = 4'd0;
        start1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) start1 = 1'b0;
            got  = obs1();
            want = {exp_vec(k, 0, 1), exp_cnt(k, 0, 1)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL zero cycle=%0d got=%h want=%h", k, got, want);
            end
        end
        $display("run zero: n=0 L=1");
    endtask

    // start held high through a 2-squaring run: first run completes (done at 8),
    // the IDLE cycle 9 re-accepts, and a second run follows from cycle 10.
    task automatic test_start_busy();
        logic [9:0] got, want;
        int d;
        d = done_cycle(2, 1);
        n1 = 4'd2;
        start1 = 1'b1;
        for (int k = 1; k <= 2 * (d + 1); k++) begin
            tick();
            got = obs1();
            if (k <= d + 1) want = {exp_vec(k, 2, 1), exp_cnt(k, 2, 1)};
            else            want = {exp_vec(k - d - 1, 2, 1), exp_cnt(k - d - 1, 2, 1)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL start_busy cycle=%0d got=%h want=%h", k, got, want);
            end
            if (k == d + 2) start1 = 1'b0;
        end
        $display("run start_busy: two runs n=2 L=1");
    endtask

    task automatic test_latency();
        logic [9:0] got, want;
        n3 = 4'd2;
        start3 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1) start3 = 1'b0;
            got  = obs3();
            want = {exp_vec(k, 2, 3), exp_cnt(k, 2, 3)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL latency cycle=%0d got=%h want=%h", k, got, want);
            end
        end
        $display("run latency: n=2 L=3");
    endtask

    // Largest count; n_iter is changed right after acceptance and must be ignored.
    task automatic test_max_count();
        logic [9:0] got, want;
        int d;
        d = done_cycle(15, 1);
        n1 = 4'd15;
        start1 = 1'b1;
        for (int k = 1; k <= d + 1; k++) begin
            tick();
            if (k == 1) begin
                start1 = 1'b0;
                n1 = 4'd1;
            end
            got  = obs1();
            want = {exp_vec(k, 15, 1), exp_cnt(k, 15, 1)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL max_count cycle=%0d got=%h want=%h", k, got, want);
            end
        end
        $display("run max_count: n=15 L=1");
    endtask

    task automatic test_reset_mid();
        logic [9:0] got, want;
        n1 = 4'd3;
        start1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) start1 = 1'b0;
            got  = obs1();
            want = {exp_vec(k, 3, 1), exp_cnt(k, 3, 1)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid_pre cycle=%0d got=%h want=%h", k, got, want);
            end
        end
        #1 rstn = 1'b0;
        #1;
        got = obs1();
        total++;
        if (got !== 10'h000) begin
            bad++;
            $display("FAIL reset_mid_async got=%h want=%h", got, 10'h000);
        end
        repeat (2) tick();
        rstn = 1'b1;
        n1 = 4'd1;
        start1 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) start1 = 1'b0;
            got  = obs1();
            want = {exp_vec(k, 1, 1), exp_cnt(k, 1, 1)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid_rerun cycle=%0d got=%h want=%h", k, got, want);
            end
        end
        $display("run reset_mid: interrupted n=3, rerun n=1");
    endtask

    // Random counts on both instances, with stray start pulses and n_iter
    // changes while busy (all of which must be ignored).
    task automatic test_random();
        logic [9:0] got, want;
        int na, nb, da, db, last;
        for (int r = 0; r < 20; r++) begin
            na = $urandom_range(0, 7);
            nb = $urandom_range(0, 5);
            da = done_cycle(na, 1);
            db = done_cycle(nb, 3);
            last = (da > db) ? da : db;
            n1 = 4'(na);
            n3 = 4'(nb);
            start1 = 1'b1;
            start3 = 1'b1;
            for (int k = 1; k <= last + 1; k++) begin
                tick();
                got  = obs1();
                want = {exp_vec(k, na, 1), exp_cnt(k, na, 1)};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL random_l1 run=%0d n=%0d cycle=%0d got=%h want=%h", r, na, k, got, want);
                end
                got  = obs3();
                want = {exp_vec(k, nb, 3), exp_cnt(k, nb, 3)};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL random_l3 run=%0d n=%0d cycle=%0d got=%h want=%h", r, nb, k, got, want);
                end
                start1 = (k < da) ? 1'($urandom_range(0, 1)) : 1'b0;
                start3 = (k < db) ? 1'($urandom_range(0, 1)) : 1'b0;
                n1 = 4'($urandom_range(0, 15));
                n3 = 4'($urandom_range(0, 15));
            end
            $display("run random %0d: L1 n=%0d, L3 n=%0d", r, na, nb);
        end
    endtask

`ifdef MUL2_SCHED_ABORT_EN
    task automatic test_abort();
        logic [9:0] got, want;
        n1 = 4'd3;
        start1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) start1 = 1'b0;
            got = obs1();
            if (k <= 3) want = {exp_vec(k, 3, 1), exp_cnt(k, 3, 1)};
            else        want = 10'h000;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL abort_seq cycle=%0d got=%h want=%h", k, got, want);
            end
            total++;
            if (aborted1 !== (k == 4)) begin
                bad++;
                $display("FAIL abort_flag cycle=%0d got=%b want=%b", k, aborted1, (k == 4));
            end
            abort1 = (k == 3);
        end
        $display("run abort: n=3 aborted at cycle 3");
    endtask
`endif

    initial begin
        total  = 0;
        bad    = 0;
        rstn   = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        n1     = '0;
        n3     = '0;
`ifdef MUL2_SCHED_ABORT_EN
        abort1 = 1'b0;
        abort3 = 1'b0;
`endif
        test_reset();
        test_single();
        test_three();
        test_zero();
        test_start_busy();
        test_latency();
        test_max_count();
        test_reset_mid();
        test_random();
`ifdef MUL2_SCHED_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
